mc_core_gen: RTL and testbench
==============================

MC_CORE_GEN -- requirements
Module: mc_core_gen

Interface
REQ-001 Parameter DW, default 8, data/address width; legal range 8..32.
REQ-002 Parameter NREG, default 16, register count; power of two, 2..2^(DW-4); RW = log2(NREG).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  memory access request.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-007 mem_addr  output  DW  access address.
REQ-008 mem_wdata  output  DW  write data.
REQ-009 mem_rdata  input  DW  read data, valid in the cycle mem_ready is high.
REQ-010 mem_ready  input  1  access completes on a rising edge where mem_req and mem_ready are both high.
REQ-011 pc  output  DW  current program counter.
REQ-012 halted  output  1  core is in HALT.

Function
REQ-013 Each instruction SHALL be two words: word1 = {opcode[DW-1:DW-4], rd[RW-1:0]}; word2 = immediate/address, or rs in [RW-1:0].
REQ-014 Opcodes SHALL be: 0 NOP; 1 LDI rd<=imm; 2 LD rd<=mem[imm]; 3 ST mem[imm]<=rd; 4 ADD rd<=rd+rs; 5 SUB rd<=rd-rs; 6 AND; 7 OR; 8 JMP pc<=imm; 9 JZ; A JC; F HALT; all others execute as NOP.
REQ-015 FSM states SHALL be FETCH1, FETCH2, EXEC, MEM and HALT.
REQ-016 FETCH1 SHALL read mem[pc]; on completion ir1<=rdata, pc<=pc+1, go to FETCH2.
REQ-017 FETCH2 SHALL read mem[pc]; on completion ir2<=rdata, pc<=pc+1, go to EXEC.
REQ-018 EXEC SHALL take one cycle with mem_req low; ALU, LDI and jump results are committed at its end.
REQ-019 From EXEC: LD/ST SHALL go to MEM, HALT to HALT, everything else to FETCH1.
REQ-020 MEM SHALL issue the access at address ir2; on completion LD writes rd, then the FSM goes to FETCH1.
REQ-021 In FETCH1, FETCH2 and MEM, mem_req SHALL stay high with addr/we/wdata stable until completion; with mem_ready low the FSM holds.
REQ-022 With zero-wait memory, latency SHALL be 3 cycles for ALU/LDI/jump/NOP and 4 cycles for LD/ST.
REQ-023 Arithmetic SHALL be modulo 2^DW; pc SHALL wrap from 2^DW-1 to 0.
REQ-024 When rd equals rs, both operands SHALL be the pre-instruction value.
REQ-025 HALT SHALL hold mem_req low and halted high until reset.

Reset
REQ-026 Reset asserted SHALL immediately force state to FETCH1, pc to 0, ir1/ir2 to 0, all registers and flags to 0, mem_req to 0 and halted to 0.
REQ-027 An access in progress at reset SHALL be abandoned with no register write.
REQ-028 The first fetch SHALL start on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro MC_CORE_GEN_FLAGS_EN SHALL control the condition flags.
REQ-030 With MC_CORE_GEN_FLAGS_EN defined: Z and C flags update only on ADD/SUB/AND/OR.
REQ-031 With the macro defined: Z = (result==0); C = carry-out for ADD, borrow for SUB, 0 for AND/OR.
REQ-032 With the macro defined: JZ/JC load pc<=imm when Z/C is 1.
REQ-033 Without MC_CORE_GEN_FLAGS_EN: no flag storage exists and JZ/JC execute as NOP.

Structure
REQ-034 Package mc_pkg SHALL hold the opcode enum (4-bit), the state enum, and word-field position constants.
REQ-035 Sub-module mc_regfile SHALL provide NREG x DW storage, two combinational read ports, one synchronous write port and async active-low clear.

Verification
REQ-036 Zero-wait memory; program LDI r1,5; LDI r2,3; ADD r1,r2; ST r1,[0x40]; HALT -> mem[0x40]=8; halted=1 after 3+3+3+4+3=16 cycles.
REQ-037 Same program with mem_ready low for 2 cycles on every access -> identical result; mem_req and mem_addr never change while stalled.
REQ-038 pc=0xFE, instruction LDI r0,0x11 at 0xFE/0xFF -> r0=0x11 and next fetch from address 0x00.
REQ-039 FLAGS_EN build: LDI r1,0xFF; LDI r2,1; ADD r1,r2; JC 0x20 -> r1=0, Z=1, C=1, pc=0x20; non-FLAGS_EN build -> pc continues sequentially.
REQ-040 Reset asserted during the MEM stall of LD r3,[0x10] -> r3 stays 0, mem_req low immediately, refetch from 0x00 after release.
REQ-041 ADD r4,r4 with r4=0x81 -> r4=0x02; SUB r5,r5 -> r5=0 and Z=1 when flags are enabled.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: opcode and FSM state encodings plus instruction-word field positions
// shared by the mc_core_gen core and its register file.
package mc_pkg;

    localparam int unsigned OPC_W  = 4;  // opcode sits in the top OPC_W bits of word1
    localparam int unsigned RD_LSB = 0;  // rd field of word1
    localparam int unsigned RS_LSB = 0;  // rs field of word2

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_JC   = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH1,
        ST_FETCH2,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    function automatic logic is_alu(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREG x DW register file, two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 16,
    parameter int unsigned RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [RW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [RW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [RW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/mc_core_gen.sv
// mc_core_gen: multi-cycle core executing two-word instructions over one memory port.
// Build option: define MC_CORE_GEN_FLAGS_EN to add Z/C flags and enable JZ/JC.
module mc_core_gen
    import mc_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] pc,
    output logic          halted
);

    localparam int unsigned RW = $clog2(NREG);

    state_e        r_state, w_state_nxt;
    logic [DW-1:0] r_pc, w_pc_nxt;
    logic [DW-1:0] r_ir1, r_ir2;
    logic          w_ld_ir1, w_ld_ir2, w_req;
    opcode_e       w_op;
    logic [RW-1:0] w_rd, w_rs;
    logic [DW-1:0] w_ra, w_rb, w_alu, w_rf_wdata;
    logic          w_carry, w_rf_we, w_take_jump;
    logic          w_unused_bits;

    assign w_op = opcode_e'(r_ir1[DW-1 -: OPC_W]);
    assign w_rd = r_ir1[RD_LSB +: RW];
    assign w_rs = r_ir2[RS_LSB +: RW];

    mc_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk       (clk),
        .rst_n     (reset),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (w_rd),
        .o_rdata_a (w_ra),
        .i_raddr_b (w_rs),
        .o_rdata_b (w_rb)
    );

    // One spare MSB carries ADD carry-out / SUB borrow.
    always_comb begin
        w_alu   = '0;
        w_carry = 1'b0;
        case (w_op)
            OP_ADD:  {w_carry, w_alu} = {1'b0, w_ra} + {1'b0, w_rb};
            OP_SUB:  {w_carry, w_alu} = {1'b0, w_ra} - {1'b0, w_rb};
            OP_AND:  w_alu = w_ra & w_rb;
            OP_OR:   w_alu = w_ra | w_rb;
            default: ;
        endcase
    end

`ifdef MC_CORE_GEN_FLAGS_EN
    logic r_z, r_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else if (r_state == ST_EXEC && is_alu(w_op)) begin
            r_z <= (w_alu == '0);
            r_c <= w_carry;
        end
    end

    assign w_take_jump = (w_op == OP_JMP) || (w_op == OP_JZ && r_z) || (w_op == OP_JC && r_c);
    assign w_unused_bits = ^r_ir1;
`else
    assign w_take_jump = (w_op == OP_JMP);
    assign w_unused_bits = ^{r_ir1, w_carry};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ld_ir1    = 1'b0;
        w_ld_ir2    = 1'b0;
        w_req       = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = r_pc;
        mem_wdata   = w_ra;
        w_rf_we     = 1'b0;
        w_rf_wdata  = w_alu;
        case (r_state)
            ST_FETCH1: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    w_ld_ir1    = 1'b1;
                    w_pc_nxt    = r_pc + DW'(1);
                    w_state_nxt = ST_FETCH2;
                end
            end
            ST_FETCH2: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    w_ld_ir2    = 1'b1;
                    w_pc_nxt    = r_pc + DW'(1);
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_op)
                    OP_LD, OP_ST: w_state_nxt = ST_MEM;
                    OP_HALT:      w_state_nxt = ST_HALT;
                    default:      w_state_nxt = ST_FETCH1;
                endcase
                if (w_take_jump) begin
                    w_pc_nxt = r_ir2;
                end
                if (w_op == OP_LDI) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = r_ir2;
                end else if (is_alu(w_op)) begin
                    w_rf_we = 1'b1;
                end
            end
            ST_MEM: begin
                w_req    = 1'b1;
                mem_addr = r_ir2;
                mem_we   = (w_op == OP_ST);
                if (mem_ready) begin
                    w_state_nxt = ST_FETCH1;
                    if (w_op == OP_LD) begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = mem_rdata;
                    end
                end
            end
            ST_HALT: ;
            default: w_state_nxt = ST_FETCH1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH1;
            r_pc    <= '0;
            r_ir1   <= '0;
            r_ir2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ld_ir1) r_ir1 <= mem_rdata;
            if (w_ld_ir2) r_ir2 <= mem_rdata;
        end
    end

    // State already sits at FETCH1 during reset; gating keeps the request low until release.
    assign mem_req = w_req & reset;
    assign pc      = r_pc;
    assign halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_mc_core_gen.sv
// tb_mc_core_gen: self-checking bench for mc_core_gen at DW=8, NREG=16.
// Expectations adapt to whether MC_CORE_GEN_FLAGS_EN is defined.
module tb_mc_core_gen;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8, OP_JZ = 4'h9, OP_JC = 4'hA, OP_HALT = 4'hF;
`ifdef MC_CORE_GEN_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_req, mem_we, mem_ready, halted;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic [7:0] pmem   [256] = '{default: 8'h00};  // program/preload image (stimulus process only)
    logic [7:0] dmem   [256] = '{default: 8'h00};  // stores from the DUT (responder only)
    logic       dvalid [256] = '{default: 1'b0};
    int unsigned stall_n  = 0;
    int unsigned wait_cnt = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [8];

    mc_core_gen #(.DW(8), .NREG(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign mem_ready = (wait_cnt >= stall_n);
    assign mem_rdata = dvalid[mem_addr] ? dmem[mem_addr] : pmem[mem_addr];

    always @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= 0;
            for (int i = 0; i < 256; i++) dvalid[i] <= 1'b0;
        end else if (mem_req) begin
            if (mem_ready) begin
                wait_cnt <= 0;
                if (mem_we) begin
                    dmem[mem_addr]   <= mem_wdata;
                    dvalid[mem_addr] <= 1'b1;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_store(input string name, input int unsigned addr, input logic [7:0] exp);
        check(name, 32'({dvalid[addr], dmem[addr]}), 32'({1'b1, exp}));
    endtask

    task automatic put(input int unsigned addr, input logic [3:0] op, input logic [3:0] rd,
                       input logic [7:0] w2);
        pmem[addr]     = {op, rd};
        pmem[addr + 1] = w2;
    endtask

    // Leaves reset asserted at a falling edge with an empty program image.
    task automatic begin_prog();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        stall_n = 0;
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic run_to_halt(input int unsigned budget, output int unsigned cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic load_sum_prog();
        put(0, OP_LDI, 4'd1, 8'h05);
        put(2, OP_LDI, 4'd2, 8'h03);
        put(4, OP_ADD, 4'd1, 8'h02);
        put(6, OP_ST, 4'd1, 8'h40);
        put(8, OP_HALT, 4'd0, 8'h00);
    endtask

    initial begin
        int unsigned cyc, cyc_exp, stalls, unstable, s, a, found;
        int unsigned regs [8];
        logic        prev_st;
        logic [17:0] sv;
        logic [3:0]  op, rd, rs;
        logic [7:0]  w2;
        logic [3:0]  oplist [11];

        vecs[0] = '{OP_ADD, 8'h05, 8'h03, 8'h08};
        vecs[1] = '{OP_ADD, 8'hFF, 8'h01, 8'h00};
        vecs[2] = '{OP_SUB, 8'h03, 8'h05, 8'hFE};
        vecs[3] = '{OP_SUB, 8'h10, 8'h10, 8'h00};
        vecs[4] = '{OP_AND, 8'hF0, 8'h3C, 8'h30};
        vecs[5] = '{OP_OR,  8'hF0, 8'h0F, 8'hFF};
        vecs[6] = '{OP_ADD, 8'hC8, 8'h64, 8'h2C};
        vecs[7] = '{4'hB,   8'h5A, 8'h33, 8'h5A};
        oplist = '{OP_NOP, OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, 4'hB, 4'hC, 4'hD, 4'hE};

        // Reset state, including across clock edges while held.
        #1 reset = 1'b0;
        #2;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(posedge clk);
        #1;
        check("rst_req_edge", 32'(mem_req), 32'd0);

        // Basic program, zero-wait.
        begin_prog();
        load_sum_prog();
        release_reset();
        check("first_fetch", 32'({mem_req, mem_we, mem_addr}), 32'({2'b10, 8'h00}));
        run_to_halt(100, cyc);
        check("sum_cycles", cyc, 32'd16);
        check_store("sum_store", 8'h40, 8'h08);
        repeat (3) @(posedge clk);
        #1;
        check("halt_hold", 32'({mem_req, halted}), 32'({1'b0, 1'b1}));

        // Same program with two wait cycles on every access.
        begin_prog();
        load_sum_prog();
        stall_n = 2;
        release_reset();
        prev_st  = mem_req && !mem_ready;
        sv       = {mem_req, mem_we, mem_addr, mem_wdata};
        cyc      = 0;
        stalls   = 0;
        unstable = 0;
        while (!halted && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev_st) begin
                stalls++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !== sv) unstable++;
            end
            prev_st = mem_req && !mem_ready;
            sv      = {mem_req, mem_we, mem_addr, mem_wdata};
        end
        check("stall_halted", 32'(halted), 32'd1);
        check("stall_cycles", cyc, 32'd38);
        check("stall_count", stalls, 32'd22);
        check("stall_stable", unstable, 32'd0);
        check_store("stall_store", 8'h40, 8'h08);

        // Table of single ALU operations.
        for (int i = 0; i < 8; i++) begin
            begin_prog();
            put(0, OP_LDI, 4'd1, vecs[i].a);
            put(2, OP_LDI, 4'd2, vecs[i].b);
            put(4, vecs[i].op, 4'd1, 8'h02);
            put(6, OP_ST, 4'd1, 8'h80);
            put(8, OP_HALT, 4'd0, 8'h00);
            release_reset();
            run_to_halt(100, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, 32'd16);
            check_store($sformatf("vec%0d_result", i), 8'h80, vecs[i].exp);
        end

        // pc wraps from 0xFF to 0x00.
        begin_prog();
        put(0, OP_JMP, 4'd0, 8'hFE);
        put(8'hFE, OP_LDI, 4'd0, 8'h11);
        release_reset();
        repeat (2) begin @(posedge clk); #1; end
        put(0, OP_ST, 4'd0, 8'h81);
        put(2, OP_HALT, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        check("jmp_pc", 32'(pc), 32'hFE);
        repeat (2) begin @(posedge clk); #1; end
        check("wrap_pc", 32'(pc), 32'h00);
        @(posedge clk);
        #1;
        check("wrap_fetch", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h00}));
        run_to_halt(100, cyc);
        check("wrap_cycles", cyc, 32'd7);
        check_store("wrap_r0", 8'h81, 8'h11);

        // Carry out of ADD drives JC; Z then drives JZ.
        begin_prog();
        put(0, OP_LDI, 4'd1, 8'hFF);
        put(2, OP_LDI, 4'd2, 8'h01);
        put(4, OP_ADD, 4'd1, 8'h02);
        put(6, OP_JC, 4'd0, 8'h20);
        put(8, OP_ST, 4'd1, 8'h86);
        put(10, OP_HALT, 4'd0, 8'h00);
        put(8'h20, OP_JZ, 4'd0, 8'h30);
        put(8'h22, OP_HALT, 4'd0, 8'h00);
        put(8'h30, OP_ST, 4'd1, 8'h87);
        put(8'h32, OP_HALT, 4'd0, 8'h00);
        release_reset();
        repeat (12) begin @(posedge clk); #1; end
        check("jc_pc", 32'(pc), FLAGS ? 32'h20 : 32'h08);
        run_to_halt(100, cyc);
        check("jc_seq_store", 32'(dvalid[8'h86]), FLAGS ? 32'd0 : 32'd1);
        check("jz_taken_store", 32'(dvalid[8'h87]), FLAGS ? 32'd1 : 32'd0);
        check("carry_r1", 32'(dmem[FLAGS ? 8'h87 : 8'h86]), 32'h00);

        // rd == rs uses pre-instruction operands; Z survives a store.
        begin_prog();
        put(0, OP_LDI, 4'd4, 8'h81);
        put(2, OP_ADD, 4'd4, 8'h04);
        put(4, OP_ST, 4'd4, 8'h83);
        put(6, OP_LDI, 4'd5, 8'h37);
        put(8, OP_SUB, 4'd5, 8'h05);
        put(10, OP_ST, 4'd5, 8'h84);
        put(12, OP_JZ, 4'd0, 8'h40);
        put(14, OP_HALT, 4'd0, 8'h00);
        put(8'h40, OP_ST, 4'd4, 8'h85);
        put(8'h42, OP_HALT, 4'd0, 8'h00);
        release_reset();
        run_to_halt(100, cyc);
        check_store("add_self", 8'h83, 8'h02);
        check_store("sub_self", 8'h84, 8'h00);
        check("sub_self_jz", 32'(dvalid[8'h85]), FLAGS ? 32'd1 : 32'd0);

        // Reset during a stalled LD abandons the load.
        begin_prog();
        put(0, OP_LD, 4'd3, 8'h10);
        put(2, OP_ST, 4'd3, 8'h82);
        put(4, OP_HALT, 4'd0, 8'h00);
        pmem[8'h10] = 8'h5A;
        stall_n = 3;
        release_reset();
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (mem_req && !mem_we && !mem_ready && mem_addr == 8'h10) found = 1;
        end
        check("ld_stall_seen", found, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_pc", 32'(pc), 32'd0);
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
        put(0, OP_ST, 4'd3, 8'h82);
        put(2, OP_HALT, 4'd0, 8'h00);
        stall_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        release_reset();
        check("abort_refetch", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h00}));
        run_to_halt(100, cyc);
        check_store("abort_r3", 8'h82, 8'h00);

        // Random programs against an instruction-level model.
        for (int p = 0; p < 6; p++) begin
            begin_prog();
            for (int k = 0; k < 16; k++) pmem[8'hA0 + k] = 8'($urandom);
            s = $urandom_range(0, 2);
            stall_n = s;
            for (int r = 0; r < 8; r++) regs[r] = 0;
            a = 0;
            cyc_exp = 0;
            for (int n = 0; n < 10; n++) begin
                op = oplist[$urandom_range(0, 10)];
                rd = 4'($urandom_range(0, 7));
                rs = 4'($urandom_range(0, 7));
                case (op)
                    OP_LDI:  w2 = 8'($urandom);
                    OP_LD:   w2 = 8'hA0 + 8'($urandom_range(0, 15));
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w2 = {4'($urandom), rs};
                    default: w2 = 8'($urandom);
                endcase
                put(a, op, rd, w2);
                a += 2;
                case (op)
                    OP_LDI: regs[rd] = w2;
                    OP_LD:  regs[rd] = pmem[w2];
                    OP_ADD: regs[rd] = (regs[rd] + regs[rs]) % 256;
                    OP_SUB: regs[rd] = (regs[rd] + 256 - regs[rs]) % 256;
                    OP_AND: regs[rd] = regs[rd] & regs[rs];
                    OP_OR:  regs[rd] = regs[rd] | regs[rs];
                    default: ;
                endcase
                cyc_exp += (op == OP_LD) ? 4 + 3 * s : 3 + 2 * s;
            end
            for (int r = 0; r < 8; r++) begin
                put(a, OP_ST, 4'(r), 8'hC0 + 8'(r));
                a += 2;
                cyc_exp += 4 + 3 * s;
            end
            put(a, OP_HALT, 4'd0, 8'h00);
            cyc_exp += 3 + 2 * s;
            release_reset();
            run_to_halt(400, cyc);
            check($sformatf("rand%0d_cycles", p), cyc, cyc_exp);
            for (int r = 0; r < 8; r++) begin
                check_store($sformatf("rand%0d_r%0d", p, r), 8'hC0 + r, 8'(regs[r]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
